// File: rtl/mic_array_scheduler.sv
// mic_array_scheduler: generates the I2S bit clock, word select and frame timing for a mic array
// and serialises the samples captured from N_MIC receivers onto a single valid/ready stream.
module mic_array_scheduler #(
    parameter int N_MIC = 8,
    parameter int DIV   = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    output logic                BCLK_OUT,
    output logic                WS_OUT,
    output logic                FRAME_START,
    input  logic [24*N_MIC-1:0] SDATA_IN,
    input  logic [N_MIC-1:0]    FRAME_RDY,
    output logic [31:0]         M_DATA,
    output logic                M_VALID,
    input  logic                M_READY,
    output logic                OVERRUN,
    input  logic                CLR_OVR
);
    localparam int DW = $clog2(DIV);
    localparam logic [1:0] S_IDLE = 2'd0, S_SCAN = 2'd1, S_SEND = 2'd2;

    logic [DW-1:0]    div_q, div_d;
    logic             bclk_q, bclk_d, ws_q, ws_d, fs_q, ovr_q, ovr_d, valid_q, valid_d;
    logic [5:0]       bitcnt_q, bitcnt_d;
    logic [1:0]       state_q, state_d;
    logic [31:0]      data_q, data_d;
    logic [N_MIC-1:0] sync1_q, sync2_q, sync3_q, pend_q, pend_d;
    logic [23:0]      hold_q [N_MIC];
    logic             tick, fall, fs_evt;
    logic [N_MIC-1:0] cap, sel_oh, keep, dropped, restore;
    logic [3:0]       sel;
    logic [23:0]      sel_word;

    assign tick    = EN && div_q == DW'(DIV - 1);
    assign fall    = tick && bclk_q;
    assign fs_evt  = fall && bitcnt_q == 6'd63;
    assign cap     = sync2_q & ~sync3_q;
    assign sel_oh  = (EN && state_q == S_SCAN) ? pend_q & (~pend_q + N_MIC'(1)) : '0;
    assign keep    = pend_q & ~sel_oh;
    assign dropped = fs_evt ? keep & ~cap : '0;
    // A word stalled in SEND when capture is disabled goes back to pending rather than being lost.
    assign restore = (!EN && state_q == S_SEND && !M_READY) ? N_MIC'(1) << data_q[27:24] : '0;

    always_comb begin
        sel      = '0;
        sel_word = '0;
        for (int i = N_MIC - 1; i >= 0; i--)
            if (pend_q[i]) begin
                sel      = 4'(i);
                sel_word = hold_q[i];
            end
    end

    always_comb begin
        div_d    = (!EN || tick) ? '0 : div_q + DW'(1);
        bclk_d   = EN && (bclk_q ^ tick);
        bitcnt_d = !EN ? 6'd63 : bitcnt_q + 6'(fall);
        ws_d     = EN && (fall ? bitcnt_d[5] : ws_q);
        pend_d   = (keep & ~dropped) | cap | restore;
        ovr_d    = |(cap & keep) || |dropped || (ovr_q && !CLR_OVR);
        state_d  = state_q;
        data_d   = data_q;
        valid_d  = valid_q;
        if (!EN) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else if (state_q == S_IDLE) begin
            state_d = |pend_d ? S_SCAN : S_IDLE;
        end else if (state_q == S_SCAN) begin
            state_d = S_SEND;
            data_d  = {4'h0, sel, sel_word};
            valid_d = 1'b1;
        end else if (state_q != S_SEND || M_READY) begin
            state_d = |pend_d ? S_SCAN : S_IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q    <= '0;
            bclk_q   <= 1'b0;
            ws_q     <= 1'b0;
            fs_q     <= 1'b0;
            bitcnt_q <= 6'd63;
            sync1_q  <= '0;
            sync2_q  <= '0;
            sync3_q  <= '0;
            pend_q   <= '0;
            ovr_q    <= 1'b0;
            state_q  <= S_IDLE;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            bclk_q   <= bclk_d;
            ws_q     <= ws_d;
            fs_q     <= fs_evt;
            bitcnt_q <= bitcnt_d;
            sync1_q  <= FRAME_RDY;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            state_q  <= state_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < N_MIC; i++)
            hold_q[i] <= RST ? '0 : cap[i] ? SDATA_IN[24*i +: 24] : hold_q[i];
    end

    assign BCLK_OUT    = bclk_q;
    assign WS_OUT      = ws_q;
    assign FRAME_START = fs_q;
    assign M_DATA      = data_q;
    assign M_VALID     = valid_q;
    assign OVERRUN     = ovr_q;
endmodule

// File: tb/tb_mic_array_scheduler.sv
// tb_mic_array_scheduler: scenario tasks for the mic array scheduler with DIV=2, N_MIC=8,
// including randomized capture batches checked against a queue of expected words.
module tb_mic_array_scheduler;
    localparam int N = 8;

    logic          CLK = 1'b0;
    logic          RST, EN, BCLK_OUT, WS_OUT, FRAME_START, M_VALID, M_READY, OVERRUN, CLR_OVR;
    logic [24*N-1:0] SDATA_IN;
    logic [N-1:0]  FRAME_RDY;
    logic [31:0]   M_DATA;
    int            vectors = 0;
    int            errs = 0;

    always #5 CLK = ~CLK;

    mic_array_scheduler #(.N_MIC(N), .DIV(2)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .BCLK_OUT(BCLK_OUT), .WS_OUT(WS_OUT),
        .FRAME_START(FRAME_START), .SDATA_IN(SDATA_IN), .FRAME_RDY(FRAME_RDY),
        .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY), .OVERRUN(OVERRUN),
        .CLR_OVR(CLR_OVR)
    );

    task automatic wait_fs;
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (FRAME_START !== 1'b1 && n < 300);
        vectors++;
        if (FRAME_START !== 1'b1) begin
            errs++;
            $display("FAIL wait_fs: FRAME_START=%b after %0d cycles, want 1", FRAME_START, n);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; EN = 1'b0; M_READY = 1'b0; CLR_OVR = 1'b0;
        FRAME_RDY = '0; SDATA_IN = '0;
        repeat (2) @(negedge CLK);
        vectors++;
        if ({BCLK_OUT, WS_OUT, FRAME_START, M_VALID, OVERRUN} !== 5'b0) begin
            errs++;
            $display("FAIL reset_flags: got %b want 00000", {BCLK_OUT, WS_OUT, FRAME_START, M_VALID, OVERRUN});
        end
        vectors++;
        if (M_DATA !== 32'h0) begin
            errs++;
            $display("FAIL reset_data: got %h want 00000000", M_DATA);
        end
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        vectors++;
        if ({BCLK_OUT, WS_OUT, FRAME_START} !== 3'b0) begin
            errs++;
            $display("FAIL en_low_idle: got %b want 000", {BCLK_OUT, WS_OUT, FRAME_START});
        end
    endtask

    task automatic test_clock;
        int n, ws_at, fs_at, bhi, rises;
        logic pb;
        EN = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (FRAME_START !== 1'b1 && n < 20);
        vectors++;
        if (n != 4 || FRAME_START !== 1'b1) begin
            errs++;
            $display("FAIL first_fs_latency: got %0d cycles want 4", n);
        end
        ws_at = -1; fs_at = -1; bhi = 0; rises = 0; pb = 1'b0;
        for (int t = 1; t <= 256; t++) begin
            @(negedge CLK);
            if (WS_OUT === 1'b1 && ws_at < 0) ws_at = t;
            if (FRAME_START === 1'b1 && fs_at < 0) fs_at = t;
            if (BCLK_OUT === 1'b1) bhi++;
            if (BCLK_OUT === 1'b1 && !pb) rises++;
            pb = BCLK_OUT;
        end
        vectors++;
        if (ws_at != 128) begin
            errs++;
            $display("FAIL ws_rise: got %0d want 128", ws_at);
        end
        vectors++;
        if (fs_at != 256) begin
            errs++;
            $display("FAIL frame_period: got %0d want 256", fs_at);
        end
        vectors++;
        if (bhi != 128 || rises != 64) begin
            errs++;
            $display("FAIL bclk_shape: high=%0d rises=%0d want 128 64", bhi, rises);
        end
        vectors++;
        if (WS_OUT !== 1'b0) begin
            errs++;
            $display("FAIL ws_at_frame: got %b want 0", WS_OUT);
        end
    endtask

    task automatic test_single;
        logic ev;
        wait_fs();
        M_READY = 1'b1;
        SDATA_IN[3*24 +: 24] = 24'hABCDEF;
        FRAME_RDY[3] = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            @(negedge CLK);
            if (t == 3) FRAME_RDY[3] = 1'b0;
            ev = (t == 4);
            vectors++;
            if (M_VALID !== ev) begin
                errs++;
                $display("FAIL single_valid t=%0d: got %b want %b", t, M_VALID, ev);
            end
            if (t == 4) begin
                vectors++;
                if (M_DATA !== 32'h03ABCDEF) begin
                    errs++;
                    $display("FAIL single_data: got %h want 03abcdef", M_DATA);
                end
            end
        end
    endtask

    task automatic test_dual;
        logic [23:0] s0, s5;
        logic ev;
        wait_fs();
        s0 = 24'($urandom);
        s5 = 24'($urandom);
        M_READY = 1'b1;
        SDATA_IN[0 +: 24] = s0;
        SDATA_IN[5*24 +: 24] = s5;
        FRAME_RDY = 8'b0010_0001;
        for (int t = 1; t <= 8; t++) begin
            @(negedge CLK);
            if (t == 3) FRAME_RDY = '0;
            ev = (t == 4 || t == 6);
            vectors++;
            if (M_VALID !== ev) begin
                errs++;
                $display("FAIL dual_valid t=%0d: got %b want %b", t, M_VALID, ev);
            end
            if (t == 4) begin
                vectors++;
                if (M_DATA !== {8'h00, s0}) begin
                    errs++;
                    $display("FAIL dual_ch0: got %h want %h", M_DATA, {8'h00, s0});
                end
            end
            if (t == 6) begin
                vectors++;
                if (M_DATA !== {8'h05, s5}) begin
                    errs++;
                    $display("FAIL dual_ch5: got %h want %h", M_DATA, {8'h05, s5});
                end
            end
        end
        vectors++;
        if (OVERRUN !== 1'b0) begin
            errs++;
            $display("FAIL dual_overrun: got %b want 0", OVERRUN);
        end
    endtask

    task automatic test_frame_drop;
        logic [23:0] s1, s2;
        int nv;
        wait_fs();
        repeat (240) @(negedge CLK);
        s1 = 24'($urandom);
        s2 = 24'($urandom);
        M_READY = 1'b0;
        SDATA_IN[1*24 +: 24] = s1;
        SDATA_IN[2*24 +: 24] = s2;
        FRAME_RDY = 8'b0000_0110;
        repeat (3) @(negedge CLK);
        FRAME_RDY = '0;
        wait_fs();
        vectors++;
        if (M_VALID !== 1'b1 || M_DATA !== {8'h01, s1}) begin
            errs++;
            $display("FAIL drop_send_held: valid=%b data=%h want 1 %h", M_VALID, M_DATA, {8'h01, s1});
        end
        vectors++;
        if (OVERRUN !== 1'b1) begin
            errs++;
            $display("FAIL drop_overrun: got %b want 1", OVERRUN);
        end
        M_READY = 1'b1;
        nv = 0;
        for (int t = 0; t < 7; t++) begin
            @(negedge CLK);
            if (M_VALID === 1'b1) nv++;
        end
        vectors++;
        if (nv != 0) begin
            errs++;
            $display("FAIL drop_no_ch2: got %0d valid cycles want 0", nv);
        end
        vectors++;
        if (OVERRUN !== 1'b1) begin
            errs++;
            $display("FAIL drop_sticky: got %b want 1", OVERRUN);
        end
        CLR_OVR = 1'b1;
        @(negedge CLK);
        CLR_OVR = 1'b0;
        vectors++;
        if (OVERRUN !== 1'b0) begin
            errs++;
            $display("FAIL drop_clear: got %b want 0", OVERRUN);
        end
    endtask

    task automatic test_overrun;
        logic [23:0] a, b, c;
        logic [31:0] got [4];
        int n;
        wait_fs();
        a = 24'($urandom); b = 24'($urandom); c = 24'($urandom);
        M_READY = 1'b0;
        SDATA_IN[0 +: 24] = a;
        FRAME_RDY[0] = 1'b1;
        repeat (3) @(negedge CLK);
        FRAME_RDY[0] = 1'b0;
        repeat (3) @(negedge CLK);
        SDATA_IN[4*24 +: 24] = b;
        FRAME_RDY[4] = 1'b1;
        repeat (3) @(negedge CLK);
        FRAME_RDY[4] = 1'b0;
        repeat (2) @(negedge CLK);
        vectors++;
        if (OVERRUN !== 1'b0) begin
            errs++;
            $display("FAIL ovr_first_capture: got %b want 0", OVERRUN);
        end
        SDATA_IN[4*24 +: 24] = c;
        FRAME_RDY[4] = 1'b1;
        repeat (3) @(negedge CLK);
        FRAME_RDY[4] = 1'b0;
        repeat (2) @(negedge CLK);
        vectors++;
        if (OVERRUN !== 1'b1) begin
            errs++;
            $display("FAIL ovr_second_capture: got %b want 1", OVERRUN);
        end
        M_READY = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (M_VALID === 1'b1 && n < 4) begin
                got[n] = M_DATA;
                n++;
            end
            @(negedge CLK);
        end
        vectors++;
        if (n != 2 || got[0] !== {8'h00, a} || got[1] !== {8'h04, c}) begin
            errs++;
            $display("FAIL ovr_words: n=%0d w0=%h w1=%h want 2 %h %h", n, got[0], got[1], {8'h00, a}, {8'h04, c});
        end
        CLR_OVR = 1'b1;
        @(negedge CLK);
        CLR_OVR = 1'b0;
        vectors++;
        if (OVERRUN !== 1'b0) begin
            errs++;
            $display("FAIL ovr_clear: got %b want 0", OVERRUN);
        end
    endtask

    task automatic test_random;
        logic [31:0] exp_q [$];
        logic [31:0] held, want;
        logic [23:0] samp;
        logic [N-1:0] mask;
        logic stalled, r;
        int extra;
        for (int batch = 0; batch < 6; batch++) begin
            wait_fs();
            mask = N'($urandom_range(1, 255));
            for (int i = 0; i < N; i++) begin
                samp = 24'($urandom);
                SDATA_IN[24*i +: 24] = samp;
                if (mask[i]) exp_q.push_back({4'h0, 4'(i), samp});
            end
            FRAME_RDY = mask;
            stalled = 1'b0;
            held = '0;
            for (int k = 0; k < 150 && exp_q.size() > 0; k++) begin
                if (k == 3) FRAME_RDY = '0;
                if (stalled) begin
                    vectors++;
                    if (M_VALID !== 1'b1 || M_DATA !== held) begin
                        errs++;
                        $display("FAIL rnd_stable: valid=%b data=%h want 1 %h", M_VALID, M_DATA, held);
                    end
                end
                r = ($urandom_range(0, 3) != 0);
                M_READY = r;
                stalled = 1'b0;
                if (M_VALID === 1'b1) begin
                    if (r) begin
                        want = exp_q.pop_front();
                        vectors++;
                        if (M_DATA !== want) begin
                            errs++;
                            $display("FAIL rnd_word: got %h want %h", M_DATA, want);
                        end
                    end else begin
                        stalled = 1'b1;
                        held = M_DATA;
                    end
                end
                @(negedge CLK);
            end
            FRAME_RDY = '0;
            M_READY = 1'b1;
            vectors++;
            if (exp_q.size() != 0) begin
                errs++;
                $display("FAIL rnd_missing: %0d words not seen", exp_q.size());
            end
            exp_q.delete();
            extra = 0;
            repeat (5) begin
                @(negedge CLK);
                if (M_VALID === 1'b1) extra++;
            end
            vectors++;
            if (extra != 0 || OVERRUN !== 1'b0) begin
                errs++;
                $display("FAIL rnd_tail: extra=%0d overrun=%b want 0 0", extra, OVERRUN);
            end
        end
    endtask

    task automatic test_reset_send;
        logic [23:0] s6, s2;
        int nv, fs_at;
        logic ev;
        wait_fs();
        s6 = 24'($urandom);
        M_READY = 1'b0;
        SDATA_IN[6*24 +: 24] = s6;
        FRAME_RDY[6] = 1'b1;
        repeat (3) @(negedge CLK);
        FRAME_RDY[6] = 1'b0;
        repeat (3) @(negedge CLK);
        vectors++;
        if (M_VALID !== 1'b1 || M_DATA !== {8'h06, s6}) begin
            errs++;
            $display("FAIL rst_pre_send: valid=%b data=%h want 1 %h", M_VALID, M_DATA, {8'h06, s6});
        end
        RST = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({BCLK_OUT, WS_OUT, FRAME_START, M_VALID, OVERRUN} !== 5'b0 || M_DATA !== 32'h0) begin
            errs++;
            $display("FAIL rst_outputs: flags=%b data=%h want 00000 00000000",
                     {BCLK_OUT, WS_OUT, FRAME_START, M_VALID, OVERRUN}, M_DATA);
        end
        RST = 1'b0;
        M_READY = 1'b1;
        nv = 0;
        fs_at = -1;
        for (int t = 1; t <= 20; t++) begin
            @(negedge CLK);
            if (M_VALID === 1'b1) nv++;
            if (FRAME_START === 1'b1 && fs_at < 0) fs_at = t;
        end
        vectors++;
        if (nv != 0) begin
            errs++;
            $display("FAIL rst_no_word: got %0d valid cycles want 0", nv);
        end
        vectors++;
        if (fs_at != 4) begin
            errs++;
            $display("FAIL rst_restart_fs: got %0d want 4", fs_at);
        end
        s2 = 24'($urandom);
        SDATA_IN[2*24 +: 24] = s2;
        FRAME_RDY[2] = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            @(negedge CLK);
            if (t == 3) FRAME_RDY[2] = 1'b0;
            ev = (t == 4);
            vectors++;
            if (M_VALID !== ev || (ev && M_DATA !== {8'h02, s2})) begin
                errs++;
                $display("FAIL rst_new_word t=%0d: valid=%b data=%h want %b %h", t, M_VALID, M_DATA, ev, {8'h02, s2});
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clock();
        test_single();
        test_dual();
        test_frame_drop();
        test_overrun();
        test_random();
        test_reset_send();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
